// File: rtl/mem_port_sequencer.sv
// Memory port sequencer: shares one single-port RAM between the core's
// instruction-fetch and load/store ports, stepping the core via c_halt.
//
// Ports:
//   clk, res        clock, asynchronous active-low reset
//   dbg_halt        external halt request, honoured only while in GO
//   c_in_addr       core instruction address
//   c_in_data       registered instruction word to core
//   c_address       core data address
//   c_data_out      core store data
//   c_data_in       registered load data to core
//   c_write_e       core store request (wins over c_read_e)
//   c_read_e        core load request
//   c_be            core byte enables
//   c_halt          halt to core, low for one cycle per completed step
//   m_req/m_we      registered memory request / write strobe
//   m_addr/m_wdata  registered memory address / write data
//   m_be            registered memory byte enables
//   m_rdata/m_ack   memory read data and one-cycle completion strobe
//   err             sticky watchdog timeout flag
module mem_port_sequencer #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        res,
    input  logic        dbg_halt,
    input  logic [31:0] c_in_addr,
    output logic [31:0] c_in_data,
    input  logic [31:0] c_address,
    input  logic [31:0] c_data_out,
    output logic [31:0] c_data_in,
    input  logic        c_write_e,
    input  logic        c_read_e,
    input  logic [3:0]  c_be,
    output logic        c_halt,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, DATA, INST, GO} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] l_iaddr;
    logic        l_read;
    logic [7:0]  cnt;

    // Release is the only output that must react to dbg_halt in the
    // same cycle, so it is decoded from the registered state.
    assign c_halt = !(state == GO && !dbg_halt);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            l_iaddr   <= '0;
            l_read    <= 1'b0;
            cnt       <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_be      <= '0;
            c_in_data <= NOP_INSN;
            c_data_in <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    l_iaddr <= c_in_addr;
                    // A combined read+write is performed as a write only.
                    l_read  <= c_read_e & ~c_write_e;
                    cnt     <= '0;
                    m_req   <= 1'b1;
                    if (c_write_e || c_read_e) begin
                        state   <= DATA;
                        m_we    <= c_write_e;
                        m_addr  <= c_address;
                        m_wdata <= c_data_out;
                        m_be    <= c_be;
                    end else begin
                        state  <= INST;
                        m_we   <= 1'b0;
                        m_addr <= c_in_addr;
                        m_be   <= 4'b1111;
                    end
                end
                DATA: begin
                    // An ack in the final watchdog cycle still wins.
                    if (m_ack || cnt == LAST) begin
                        if (m_ack) begin
                            if (l_read) c_data_in <= m_rdata;
                        end else begin
                            c_data_in <= '0;
                            err       <= 1'b1;
                        end
                        state  <= INST;
                        cnt    <= '0;
                        m_we   <= 1'b0;
                        m_addr <= l_iaddr;
                        m_be   <= 4'b1111;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                INST: begin
                    if (m_ack || cnt == LAST) begin
                        if (m_ack) begin
                            c_in_data <= m_rdata;
                        end else begin
                            c_in_data <= NOP_INSN;
                            err       <= 1'b1;
                        end
                        state <= GO;
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        m_be  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GO: begin
                    if (!dbg_halt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench for mem_port_sequencer: directed and randomized
// core steps checked against a step-level reference model.
module tb_mem_port_sequencer;

    localparam int T = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        dbg_halt = 1'b0;
    logic [31:0] c_in_addr = '0;
    logic [31:0] c_in_data;
    logic [31:0] c_address = '0;
    logic [31:0] c_data_out = '0;
    logic [31:0] c_data_in;
    logic        c_write_e = 1'b0;
    logic        c_read_e = 1'b0;
    logic [3:0]  c_be = '0;
    logic        c_halt;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_dout = '0;
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_port_sequencer #(.TIMEOUT(T), .NOP_INSN(NOP)) dut (
        .clk(clk), .res(res), .dbg_halt(dbg_halt),
        .c_in_addr(c_in_addr), .c_in_data(c_in_data),
        .c_address(c_address), .c_data_out(c_data_out),
        .c_data_in(c_data_in), .c_write_e(c_write_e),
        .c_read_e(c_read_e), .c_be(c_be), .c_halt(c_halt),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata),
        .m_ack(m_ack), .err(err)
    );

    // One core step. dwait/iwait = wait cycles before ack (>= T: never).
    // dbg_n = number of GO cycles dbg_halt is held high.
    task automatic do_step(
        input logic wr, input logic rd,
        input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] be, input logic [31:0] iaddr,
        input int dwait, input int iwait,
        input logic [31:0] drd, input logic [31:0] insn,
        input int dbg_n, input string nm
    );
        logic has_d;
        logic ack;
        logic exp_halt;
        logic [31:0] exp_insn;
        int dlen, ilen, total, cyc, ph, pc, gocyc;
        bit released;
        has_d = wr | rd;
        dlen = !has_d ? 0 : (dwait < T ? dwait + 1 : T);
        ilen = iwait < T ? iwait + 1 : T;
        total = 1 + dlen + ilen + dbg_n + 1;
        if (has_d) begin
            if (dwait >= T) begin
                exp_dout = '0;
                exp_err = 1'b1;
            end else if (rd && !wr) begin
                exp_dout = drd;
            end
        end
        exp_insn = iwait < T ? insn : NOP;
        if (iwait >= T) exp_err = 1'b1;

        c_write_e = wr; c_read_e = rd; c_address = addr;
        c_data_out = wdata; c_be = be; c_in_addr = iaddr;
        cyc = 0; ph = 0; pc = 0; gocyc = 0; released = 0;
        while (!released && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ph == 3) dbg_halt = (gocyc < dbg_n);
            else dbg_halt = dbg_n > 0 ? 1'b1 : 1'($urandom_range(0, 1));
            if (ph == 1) ack = (pc == dwait);
            else if (ph == 2) ack = (pc == iwait);
            else ack = 1'($urandom_range(0, 1));
            m_ack = ack;
            if (ack && ph == 1) m_rdata = drd;
            else if (ack && ph == 2) m_rdata = insn;
            else m_rdata = $urandom;
            #1;
            exp_halt = !(ph == 3 && !dbg_halt);
            n_chk++;
            if (c_halt !== exp_halt) begin
                n_fail++;
                $display("FAIL %s c_halt cyc%0d: got %b want %b",
                         nm, cyc, c_halt, exp_halt);
            end
            n_chk++;
            if (m_req !== (ph == 1 || ph == 2)) begin
                n_fail++;
                $display("FAIL %s m_req cyc%0d: got %b want %b",
                         nm, cyc, m_req, (ph == 1 || ph == 2));
            end
            if (ph == 1) begin
                n_chk++;
                if ({m_we, m_addr, m_wdata, m_be} !==
                    {wr, addr, wdata, be}) begin
                    n_fail++;
                    $display("FAIL %s data req: got we%b a%h d%h be%h want we%b a%h d%h be%h",
                             nm, m_we, m_addr, m_wdata, m_be,
                             wr, addr, wdata, be);
                end
            end
            if (ph == 2) begin
                n_chk++;
                if ({m_we, m_addr, m_be} !== {1'b0, iaddr, 4'hf}) begin
                    n_fail++;
                    $display("FAIL %s fetch req: got we%b a%h be%h want we0 a%h be f",
                             nm, m_we, m_addr, m_be, iaddr);
                end
            end
            if (ph == 3) begin
                n_chk++;
                if (c_in_data !== exp_insn || c_data_in !== exp_dout) begin
                    n_fail++;
                    $display("FAIL %s GO data: got i%h d%h want i%h d%h",
                             nm, c_in_data, c_data_in, exp_insn, exp_dout);
                end
                if (!c_halt) released = 1;
                gocyc++;
            end
            pc++;
            if (ph == 0) begin
                ph = has_d ? 1 : 2; pc = 0;
            end else if (ph == 1 && pc == dlen) begin
                ph = 2; pc = 0;
            end else if (ph == 2 && pc == ilen) begin
                ph = 3; pc = 0;
            end
        end
        m_ack = 1'b0;
        dbg_halt = 1'b0;
        n_chk++;
        if (!released || cyc !== total) begin
            n_fail++;
            $display("FAIL %s step length: got %0d (released=%0d) want %0d",
                     nm, cyc, released, total);
        end
        n_chk++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b", nm, err, exp_err);
        end
    endtask

    task automatic test_reset();
        res = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({c_halt, m_req, m_we, m_be, m_addr, m_wdata, c_in_data,
             c_data_in, err} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             NOP, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset values: halt%b req%b we%b be%h a%h d%h i%h r%h e%b",
                     c_halt, m_req, m_we, m_be, m_addr, m_wdata,
                     c_in_data, c_data_in, err);
        end
        @(posedge clk);
        #1 res = 1'b1;
    endtask

    task automatic test_fetch();
        do_step(0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_0000,
                0, 0, 32'h0, 32'h0050_0093, 0, "fetch");
    endtask

    task automatic test_load();
        do_step(0, 1, 32'h104, 32'h0, 4'hf, 32'h0000_0004,
                2, 0, 32'hDEAD_BEEF, 32'h0000_0033, 0, "load");
    endtask

    task automatic test_store();
        do_step(1, 0, 32'h203, 32'hAB00_0000, 4'b1000, 32'h8,
                0, 1, 32'h1111_2222, 32'h0010_0113, 0, "store");
        do_step(1, 1, 32'h300, 32'h5555_AAAA, 4'b0011, 32'hC,
                1, 0, 32'h7777_8888, 32'h0020_0193, 0, "rdwr");
    endtask

    task automatic test_race();
        do_step(0, 1, 32'h40, 32'h0, 4'hf, 32'h10,
                T - 1, T - 1, 32'h1234_5678, 32'h0BAD_F00D, 0, "race");
    endtask

    task automatic test_timeout();
        do_step(0, 0, 32'h0, 32'h0, 4'h0, 32'h14,
                0, 99, 32'h0, 32'hFFFF_FFFF, 0, "fetch_to");
        do_step(0, 1, 32'h50, 32'h0, 4'hf, 32'h18,
                99, 0, 32'hCAFE_0000, 32'h0000_00B3, 0, "data_to");
        do_step(0, 0, 32'h0, 32'h0, 4'h0, 32'h1C,
                0, 0, 32'h0, 32'h0030_0213, 0, "after_to");
    endtask

    task automatic test_dbg_halt();
        do_step(0, 0, 32'h0, 32'h0, 4'h0, 32'h20,
                0, 0, 32'h0, 32'h0040_0293, 5, "dbg_halt");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            do_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, 4'($urandom),
                    $urandom, int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 5)), $urandom, $urandom,
                    int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_reset_mid_access();
        c_read_e = 1'b1; c_write_e = 1'b0;
        c_address = 32'h600; c_be = 4'hf; c_in_addr = 32'h24;
        m_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (m_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset pre: m_req got %b want 1", m_req);
        end
        #2 res = 1'b0;
        #1;
        n_chk++;
        if ({m_req, c_halt, err, c_in_data, c_data_in} !==
            {1'b0, 1'b1, 1'b0, NOP, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_reset: req%b halt%b err%b i%h d%h want 0 1 0 %h 0",
                     m_req, c_halt, err, c_in_data, c_data_in, NOP);
        end
        exp_err = 1'b0;
        exp_dout = '0;
        @(posedge clk);
        #1 res = 1'b1;
        do_step(0, 1, 32'h604, 32'h0, 4'hf, 32'h28,
                0, 0, 32'h0A0B_0C0D, 32'h0050_0313, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_race();
        test_timeout();
        test_dbg_halt();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Shares one single-port RAM between the core's instruction-fetch port and its load/store port.
- Drives the core's halt input so that each core step completes an optional data access first, then the instruction fetch.
- Returns registered fetch/read data to the core and releases it for exactly one clock per step.
- Sits between the core and the SoC RAM; includes a watchdog so a silent memory cannot hang the core.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for m_ack per access (1..255).
- NOP_INSN, 32'h00000013: instruction word returned on fetch timeout and held after reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- res  in  1  asynchronous, active-low reset
- dbg_halt  in  1  external halt request (debugger/SoC)
- c_in_addr  in  32  core instruction address
- c_in_data  out  32  instruction word to core (registered)
- c_address  in  32  core data address
- c_data_out  in  32  core store data
- c_data_in  out  32  load data to core (registered)
- c_write_e  in  1  core store request
- c_read_e  in  1  core load request
- c_be  in  4  core byte enables
- c_halt  out  1  halt to core
- m_req  out  1  memory request, held until m_ack or timeout
- m_we  out  1  memory write
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_be  out  4  memory byte enables
- m_rdata  in  32  memory read data, valid with m_ack
- m_ack  in  1  one-cycle completion strobe
- err  out  1  sticky timeout flag

Behaviour:
- Reset (res=0, asynchronous): state=IDLE, c_halt=1, m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, c_in_data=NOP_INSN, c_data_in=0, err=0, timeout counter=0.
- Reset asserted mid-access drops m_req immediately. Memory must tolerate an abandoned request.
- c_halt=1 in every state except GO.
- The core holds all c_* inputs stable while halted.

States:
- IDLE: latch c_in_addr, c_address, c_data_out, c_be, c_write_e, c_read_e.
  - If c_write_e or c_read_e → DATA, else → INST.
  - If both c_write_e and c_read_e: treat as write, do not capture read data.
- DATA:
  - Drive m_req=1, m_we=latched write, m_addr=latched c_address, m_wdata=latched c_data_out, m_be=latched c_be.
  - On m_ack: if read, c_data_in<=m_rdata. → INST.
- INST:
  - Drive m_req=1, m_we=0, m_addr=latched c_in_addr, m_be=4'b1111.
  - On m_ack: c_in_data<=m_rdata. → GO.
- GO:
  - If dbg_halt=0: c_halt=0 for this one cycle, → IDLE.
  - If dbg_halt=1: stay in GO with c_halt=1 until dbg_halt=0, then release for one cycle.
  - dbg_halt has no effect in other states; the sequence always completes first.

Timing and outputs:
- m_req/m_we/m_addr/m_wdata/m_be are registered. They are valid starting the cycle the state is entered, and m_req drops the cycle after m_ack.
- m_ack outside DATA/INST is ignored.
- Minimum step with zero-wait memory (m_ack in the first request cycle):
  - fetch only: IDLE, INST, GO = 3 cycles.
  - with data access: 4 cycles.
- c_in_data and c_data_in change only on m_ack capture, a timeout, or reset. They are stable throughout GO.

Watchdog:
- Counter cleared on entry to DATA/INST and incremented each cycle without m_ack.
- When the count reaches TIMEOUT-1 with no ack: abort the access and set err=1.
  - DATA: c_data_in<=0, → INST.
  - INST: c_in_data<=NOP_INSN, → GO.
- m_ack arriving in the same cycle as the timeout wins: data is captured and err is not set.
- err clears only on reset.

Test Plan:
- Reset then fetch: res low 3 cycles, release; memory acks 0x00500093 on the first INST cycle → c_halt low for exactly one cycle at cycle 3 after release, c_in_data=0x00500093, m_we never 1.
- Load: c_read_e=1, c_address=0x104, c_be=4'b1111; memory returns 0xDEADBEEF after 2 waits, then fetch acks immediately → m_addr 0x104 then c_in_addr, c_data_in=0xDEADBEEF, c_halt released once, 6 cycles total.
- Store byte: c_write_e=1, c_address=0x203, c_data_out=0xAB000000, c_be=4'b1000 → one request with m_we=1, m_be=4'b1000, m_wdata=0xAB000000; c_data_in unchanged.
- Timeout: TIMEOUT=4, memory never acks on fetch → m_req high 4 cycles then low, c_in_data=0x00000013, err=1 and remains 1 across later normal steps.
- Ack vs. timeout race: m_ack asserted in the TIMEOUT-1 cycle with 0x12345678 → captured, err stays 0.
- dbg_halt held high through GO for 5 cycles → c_halt stays 1, released for one cycle after dbg_halt falls. res pulsed low during DATA → m_req 0 in the same cycle, state IDLE.
